decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
- Registered instruction-decode stage for the RV32IM pipeline. It sits between the IF/ID buffer and the EX stage.
- Decodes one instruction into the full control bundle and holds it in the ID/EX output register.
- Handshakes with IF using VALID/READY and with EX using VALID/READY.
- Inserts a bubble for load-use hazards and blocks issue while a multi-cycle DIV/REM occupies EX.
- Decodes R-, B- and AUIPC types with distinct opcodes: R = 0110011, B = 1100011, AUIPC = 0010111.

Parameters:
- XLEN, 32, width of PC and data path.
- ALUOP_W, 5, width of the ALU opcode field.
- MDIV_LATENCY, 4, issue-block cycles after a DIV/DIVU/REM/REMU is accepted by EX. A value of 0 disables blocking.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IF_VALID  in  1  an instruction is offered.
- INSTRUCTION  in  32  offered instruction.
- PC  in  XLEN  PC of the offered instruction.
- ID_READY  out  1  stage accepts this cycle.
- FLUSH  in  1  squash request from EX (taken branch or jump).
- EX_READY  in  1  EX consumes the output register.
- EX_VALID  out  1  output register holds a valid instruction.
- EX_PC  out  XLEN  registered PC.
- EX_RD, EX_RS1, EX_RS2  out  5 each  register indices.
- EX_FUNCT3  out  3  registered funct3, used for branch compare and load/store size.
- EX_ALU_OPCODE  out  ALUOP_W  ALU operation.
- EX_IMMEDIATE_TYPE  out  3  immediate format: I=000, S=001, J=010, U=011, B=100.
- EX_WRITE_ENABLE, EX_MEM_READ, EX_MEM_WRITE, EX_JUMP_AND_LINK, EX_IMMEDIATE_SELECT, EX_OFFSET_GENERATOR, EX_BRANCH, EX_JUMP  out  1 each  control flags.
- EX_ILLEGAL  out  1  undecodable instruction.
- MDIV_BUSY  out  1  issue-block counter is non-zero.

Behaviour:
- Reset (RESET=0, asynchronous):
  - All EX_* outputs are 0, EX_VALID=0, counter=0, MDIV_BUSY=0.
  - ID_READY is 0 while RESET is low.
  - A reset during a stall or while the counter is running discards all state.
- Fire: accept = IF_VALID & ID_READY. The output register loads on the same edge, so latency is 1 cycle.
- Ready rule: ID_READY = (!EX_VALID | EX_READY) & !hazard & (counter==0) & !FLUSH.
- Output register update, in priority order:
  1. FLUSH=1: EX_VALID becomes 0 and the counter clears. Any simultaneous IF offer is not accepted.
  2. Otherwise, on accept: load the decoded bundle and set EX_VALID=1.
  3. Otherwise, if EX_READY: EX_VALID becomes 0 (bubble) and the other outputs hold their values.
  4. Otherwise: hold everything.
- Hazard: EX_VALID & EX_MEM_READ & EX_RD≠0 & (EX_RD==rs1 where rs1 is used, or EX_RD==rs2 where rs2 is used).
  - rs1 is used by every format except LUI, AUIPC and JAL.
  - rs2 is used by R, S and B formats.
  - Effect: exactly one bubble per load-use pair.
- Counter:
  - Loads MDIV_LATENCY when EX_VALID & EX_READY & EX_ALU_OPCODE∈{01100..01111}.
  - Decrements by 1 per cycle until it reaches 0.
  - MDIV_BUSY = (counter≠0).
- Decode for R-type (funct7/funct3 → ALU opcode):
  - funct7=0000000: ADD=00000, SLL=00110, SLT=10000, XOR=00011, SRL=00101, OR=00010, AND=00100. SLTU=10010 (new code).
  - funct7=0100000: SUB=00001, SRA=00111.
  - funct7=0000001: MUL=01000, MULH=01001, MULHSU=01011, MULHU=01010, DIV=01100, DIVU=01101, REM=01110, REMU=01111.
- Decode for I-ALU: ADDI, SLTI, SLTIU, XORI, ORI and ANDI map to the R-type codes above.
  - SLLI/SRLI require funct7=0000000; SRAI requires funct7=0100000.
- Control flags for the other formats:
  - Loads: 00000, WRITE_ENABLE=1, MEM_READ=1, IMMEDIATE_SELECT=1.
  - Stores: 00000, MEM_WRITE=1, IMMEDIATE_SELECT=1.
  - JAL: JUMP=1, JUMP_AND_LINK=1, OFFSET_GENERATOR=1, WRITE_ENABLE=1.
  - JALR: JUMP=1, JUMP_AND_LINK=1, WRITE_ENABLE=1, IMMEDIATE_SELECT=1.
  - LUI: 10001, WRITE_ENABLE=1, IMMEDIATE_SELECT=1.
  - AUIPC: 00000, OFFSET_GENERATOR=1, WRITE_ENABLE=1, IMMEDIATE_SELECT=1.
  - B-type: 00000, BRANCH=1, OFFSET_GENERATOR=1, IMMEDIATE_SELECT=1.
- Undecodable opcode or funct combination: treated as a NOP, with all flags 0 and ALU opcode 00000.
- WRITE_ENABLE is forced to 0 when rd=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: undecodable instructions set EX_ILLEGAL=1, with all write, memory, jump and branch flags forced to 0. EX_VALID=1 so the trap travels down the pipeline.
- Undefined: EX_ILLEGAL is tied to 0 and the instruction decodes as a NOP.

Decomposition:
- Shared package rv32_ctrl_pkg, containing:
  - opcode constants;
  - ALU opcode constants;
  - immediate-type constants;
  - the control bundle struct/typedef;
  - the set of DIV-class opcodes.
- Sub-module rv32_decode_comb: pure combinational decode from INSTRUCTION to bundle plus rs-used flags, instantiated inside.

Test Plan:
- Reset then 0x002081B3 (ADD x3,x1,x2) with EX_READY=1 → next cycle EX_VALID=1, ALU=00000, WRITE_ENABLE=1, EX_RD=3, IMMEDIATE_SELECT=0.
- 0x0000A283 (LW x5,0(x1)) then 0x00528333 (ADD x6,x5,x5) → ID_READY=0 for 1 cycle, one bubble with EX_VALID=0, then ADD issues.
- 0x0220C3B3 (DIV x7,x1,x2) accepted by EX, MDIV_LATENCY=4 → MDIV_BUSY=1 and ID_READY=0 for exactly 4 cycles.
- 0x00208063 (BEQ) → BRANCH=1, IMMEDIATE_TYPE=100, WRITE_ENABLE=0. FLUSH in the next cycle with IF_VALID=1 → EX_VALID=0 and the instruction is not accepted.
- 0xFFFFFFFF → EX_ILLEGAL=1 and all flags 0 with DECODE_ILLEGAL_TRAP_EN defined; NOP with EX_ILLEGAL=0 without it.
- EX_READY=0 for 3 cycles while IF_VALID=1 → outputs stable and ID_READY=0. Assert RESET low mid-hold → outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared definitions for the RV32IM decode stage:
//   - major opcode and funct7 constants
//   - ALU opcode and immediate-format constants
//   - ctrl_t, the registered control bundle handed to EX
//   - helpers mapping funct3 to ALU opcodes and classifying DIV-class ops
// -----------------------------------------------------------------------------
package rv32_ctrl_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 groups
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU opcodes
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_OR     = 5'b00010;
  localparam logic [4:0] ALU_XOR    = 5'b00011;
  localparam logic [4:0] ALU_AND    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SLL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_MUL    = 5'b01000;
  localparam logic [4:0] ALU_MULH   = 5'b01001;
  localparam logic [4:0] ALU_MULHU  = 5'b01010;
  localparam logic [4:0] ALU_MULHSU = 5'b01011;
  localparam logic [4:0] ALU_DIV    = 5'b01100;
  localparam logic [4:0] ALU_DIVU   = 5'b01101;
  localparam logic [4:0] ALU_REM    = 5'b01110;
  localparam logic [4:0] ALU_REMU   = 5'b01111;
  localparam logic [4:0] ALU_SLT    = 5'b10000;
  localparam logic [4:0] ALU_LUI    = 5'b10001;
  localparam logic [4:0] ALU_SLTU   = 5'b10010;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  // Control bundle held in the ID/EX register
  typedef struct packed {
    logic [4:0] alu_op;
    logic [2:0] imm_type;
    logic       write_enable;
    logic       mem_read;
    logic       mem_write;
    logic       jump_and_link;
    logic       imm_select;
    logic       offset_gen;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // funct3 -> ALU opcode for the funct7=0000000 group (also ADDI..ANDI)
  function automatic logic [4:0] alu_base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // funct3 -> ALU opcode for the M extension group
  function automatic logic [4:0] muldiv_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      3'b111:  op = ALU_REMU;
      default: op = ALU_MUL;
    endcase
    return op;
  endfunction

  // DIV/DIVU/REM/REMU occupy the codes 01100..01111
  function automatic logic is_div_class(input logic [4:0] op);
    return (op[4:2] == 3'b011);
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe_if
// Bundles the IF-side handshake, the EX-side handshake and the registered
// control outputs of the decode stage.
//   master : upstream/downstream environment (drives IF offer, FLUSH, EX_READY)
//   slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface decode_ctrl_pipe_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
);
  logic               IF_VALID;
  logic [31:0]        INSTRUCTION;
  logic [XLEN-1:0]    PC;
  logic               ID_READY;
  logic               FLUSH;
  logic               EX_READY;
  logic               EX_VALID;
  logic [XLEN-1:0]    EX_PC;
  logic [4:0]         EX_RD;
  logic [4:0]         EX_RS1;
  logic [4:0]         EX_RS2;
  logic [2:0]         EX_FUNCT3;
  logic [ALUOP_W-1:0] EX_ALU_OPCODE;
  logic [2:0]         EX_IMMEDIATE_TYPE;
  logic               EX_WRITE_ENABLE;
  logic               EX_MEM_READ;
  logic               EX_MEM_WRITE;
  logic               EX_JUMP_AND_LINK;
  logic               EX_IMMEDIATE_SELECT;
  logic               EX_OFFSET_GENERATOR;
  logic               EX_BRANCH;
  logic               EX_JUMP;
  logic               EX_ILLEGAL;
  logic               MDIV_BUSY;

  modport master (
    output IF_VALID, INSTRUCTION, PC, FLUSH, EX_READY,
    input  ID_READY, EX_VALID, EX_PC, EX_RD, EX_RS1, EX_RS2, EX_FUNCT3,
           EX_ALU_OPCODE, EX_IMMEDIATE_TYPE, EX_WRITE_ENABLE, EX_MEM_READ,
           EX_MEM_WRITE, EX_JUMP_AND_LINK, EX_IMMEDIATE_SELECT,
           EX_OFFSET_GENERATOR, EX_BRANCH, EX_JUMP, EX_ILLEGAL, MDIV_BUSY
  );

  modport slave (
    input  IF_VALID, INSTRUCTION, PC, FLUSH, EX_READY,
    output ID_READY, EX_VALID, EX_PC, EX_RD, EX_RS1, EX_RS2, EX_FUNCT3,
           EX_ALU_OPCODE, EX_IMMEDIATE_TYPE, EX_WRITE_ENABLE, EX_MEM_READ,
           EX_MEM_WRITE, EX_JUMP_AND_LINK, EX_IMMEDIATE_SELECT,
           EX_OFFSET_GENERATOR, EX_BRANCH, EX_JUMP, EX_ILLEGAL, MDIV_BUSY
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// -----------------------------------------------------------------------------
// rv32_decode_comb
// Purely combinational RV32IM decoder.
//   i_instr     : instruction word
//   o_ctrl      : control bundle (ALU op, immediate format, flags)
//   o_rs1_used  : instruction reads rs1
//   o_rs2_used  : instruction reads rs2
//   o_rd/o_rs1/o_rs2/o_funct3 : raw register index and funct3 fields
// Build option: DECODE_ILLEGAL_TRAP_EN -- when defined, undecodable words set
// o_ctrl.illegal; otherwise they decode as a plain NOP.
// -----------------------------------------------------------------------------
module rv32_decode_comb
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_rs1_used,
  output logic        o_rs2_used,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic       w_legal;

  assign w_opcode = i_instr[6:0];
  assign o_rd     = i_instr[11:7];
  assign o_funct3 = i_instr[14:12];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];

  // Opcode/funct decode into the control bundle and operand-usage flags
  always_comb begin
    o_ctrl     = '0;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    w_legal    = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        o_ctrl.write_enable = 1'b1;
        o_rs1_used          = 1'b1;
        o_rs2_used          = 1'b1;
        case (w_funct7)
          F7_BASE:   o_ctrl.alu_op = alu_base_op(o_funct3);
          F7_MULDIV: o_ctrl.alu_op = muldiv_op(o_funct3);
          F7_ALT: begin
            case (o_funct3)
              3'b000:  o_ctrl.alu_op = ALU_SUB;
              3'b101:  o_ctrl.alu_op = ALU_SRA;
              default: w_legal = 1'b0;
            endcase
          end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        o_ctrl.write_enable = 1'b1;
        o_ctrl.imm_select   = 1'b1;
        o_ctrl.imm_type     = IMM_I;
        o_rs1_used          = 1'b1;
        case (o_funct3)
          3'b001: begin
            // Shift-immediates carry a funct7 that must be exact
            o_ctrl.alu_op = ALU_SLL;
            w_legal       = (w_funct7 == F7_BASE);
          end
          3'b101: begin
            case (w_funct7)
              F7_BASE: o_ctrl.alu_op = ALU_SRL;
              F7_ALT:  o_ctrl.alu_op = ALU_SRA;
              default: w_legal = 1'b0;
            endcase
          end
          default: o_ctrl.alu_op = alu_base_op(o_funct3);
        endcase
      end
      OPC_LOAD: begin
        o_ctrl.write_enable = 1'b1;
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.imm_select   = 1'b1;
        o_ctrl.imm_type     = IMM_I;
        o_rs1_used          = 1'b1;
        case (o_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
          default:                                w_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.imm_select = 1'b1;
        o_ctrl.imm_type   = IMM_S;
        o_rs1_used        = 1'b1;
        o_rs2_used        = 1'b1;
        case (o_funct3)
          3'b000, 3'b001, 3'b010: w_legal = 1'b1;
          default:                w_legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        o_ctrl.branch     = 1'b1;
        o_ctrl.offset_gen = 1'b1;
        o_ctrl.imm_select = 1'b1;
        o_ctrl.imm_type   = IMM_B;
        o_rs1_used        = 1'b1;
        o_rs2_used        = 1'b1;
        case (o_funct3)
          3'b010, 3'b011: w_legal = 1'b0;
          default:        w_legal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        o_ctrl.jump          = 1'b1;
        o_ctrl.jump_and_link = 1'b1;
        o_ctrl.offset_gen    = 1'b1;
        o_ctrl.write_enable  = 1'b1;
        o_ctrl.imm_type      = IMM_J;
      end
      OPC_JALR: begin
        o_ctrl.jump          = 1'b1;
        o_ctrl.jump_and_link = 1'b1;
        o_ctrl.write_enable  = 1'b1;
        o_ctrl.imm_select    = 1'b1;
        o_ctrl.imm_type      = IMM_I;
        o_rs1_used           = 1'b1;
        w_legal              = (o_funct3 == 3'b000);
      end
      OPC_LUI: begin
        o_ctrl.alu_op       = ALU_LUI;
        o_ctrl.write_enable = 1'b1;
        o_ctrl.imm_select   = 1'b1;
        o_ctrl.imm_type     = IMM_U;
      end
      OPC_AUIPC: begin
        o_ctrl.offset_gen   = 1'b1;
        o_ctrl.write_enable = 1'b1;
        o_ctrl.imm_select   = 1'b1;
        o_ctrl.imm_type     = IMM_U;
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      // Undecodable: all side effects suppressed; no operands read
      o_ctrl     = '0;
      o_rs1_used = 1'b0;
      o_rs2_used = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      o_ctrl.illegal = 1'b1;
`else
      o_ctrl.illegal = 1'b0;
`endif
    end else begin
      // x0 is never written
      o_ctrl.write_enable = o_ctrl.write_enable & (o_rd != 5'd0);
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe
// Registered RV32IM instruction-decode stage between IF/ID and EX.
// Ports:
//   CLK    : clock, rising edge
//   RESET  : asynchronous active-low reset
//   bus    : decode_ctrl_pipe_if.slave
//            in : IF_VALID, INSTRUCTION, PC, FLUSH, EX_READY
//            out: ID_READY, EX_VALID, EX_PC, EX_RD/RS1/RS2, EX_FUNCT3,
//                 EX_ALU_OPCODE, EX_IMMEDIATE_TYPE, control flags,
//                 EX_ILLEGAL, MDIV_BUSY
// Parameters: XLEN, ALUOP_W, MDIV_LATENCY (0 disables the DIV issue block).
// Build option: DECODE_ILLEGAL_TRAP_EN (illegal-instruction trap flag).
// -----------------------------------------------------------------------------
module decode_ctrl_pipe
  import rv32_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ALUOP_W      = 5,
  parameter int MDIV_LATENCY = 4
) (
  input logic              CLK,
  input logic              RESET,
  decode_ctrl_pipe_if.slave bus
);

  localparam int CNT_W = (MDIV_LATENCY < 1) ? 1 : $clog2(MDIV_LATENCY + 1);

  ctrl_t            w_ctrl;
  logic             w_rs1_used;
  logic             w_rs2_used;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [2:0]       w_funct3;
  logic             w_hazard;
  logic             w_ready;
  logic             w_accept;
  logic             w_div_issue;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [2:0]       r_funct3;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_cnt;

  rv32_decode_comb u_decode (
    .i_instr    (bus.INSTRUCTION),
    .o_ctrl     (w_ctrl),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used),
    .o_rd       (w_rd),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_funct3   (w_funct3)
  );

  // Load in EX whose destination feeds an operand of the offered instruction
  assign w_hazard = r_valid & r_ctrl.mem_read & (r_rd != 5'd0) &
                    ((w_rs1_used & (r_rd == w_rs1)) |
                     (w_rs2_used & (r_rd == w_rs2)));

  // RESET term keeps ready low during reset without waiting for a clock
  assign w_ready = RESET & (~r_valid | bus.EX_READY) & ~w_hazard &
                   (r_cnt == {CNT_W{1'b0}}) & ~bus.FLUSH;

  assign w_accept    = bus.IF_VALID & w_ready;
  assign w_div_issue = r_valid & bus.EX_READY & is_div_class(r_ctrl.alu_op);

  // ID/EX output register: flush > accept > drain (bubble) > hold
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid  <= 1'b0;
      r_pc     <= {XLEN{1'b0}};
      r_rd     <= 5'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_funct3 <= 3'd0;
      r_ctrl   <= '0;
    end else if (bus.FLUSH) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_pc     <= bus.PC;
      r_rd     <= w_rd;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_funct3 <= w_funct3;
      r_ctrl   <= w_ctrl;
    end else if (bus.EX_READY) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // DIV-class issue-block counter, armed when EX takes a divide
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (bus.FLUSH) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_div_issue) begin
      r_cnt <= CNT_W'(MDIV_LATENCY);
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bus.ID_READY            = w_ready;
  assign bus.EX_VALID            = r_valid;
  assign bus.EX_PC               = r_pc;
  assign bus.EX_RD               = r_rd;
  assign bus.EX_RS1              = r_rs1;
  assign bus.EX_RS2              = r_rs2;
  assign bus.EX_FUNCT3           = r_funct3;
  assign bus.EX_ALU_OPCODE       = ALUOP_W'(r_ctrl.alu_op);
  assign bus.EX_IMMEDIATE_TYPE   = r_ctrl.imm_type;
  assign bus.EX_WRITE_ENABLE     = r_ctrl.write_enable;
  assign bus.EX_MEM_READ         = r_ctrl.mem_read;
  assign bus.EX_MEM_WRITE        = r_ctrl.mem_write;
  assign bus.EX_JUMP_AND_LINK    = r_ctrl.jump_and_link;
  assign bus.EX_IMMEDIATE_SELECT = r_ctrl.imm_select;
  assign bus.EX_OFFSET_GENERATOR = r_ctrl.offset_gen;
  assign bus.EX_BRANCH           = r_ctrl.branch;
  assign bus.EX_JUMP             = r_ctrl.jump;
  assign bus.EX_ILLEGAL          = r_ctrl.illegal;
  assign bus.MDIV_BUSY           = (r_cnt != {CNT_W{1'b0}});

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_pipe
// Directed self-checking bench for decode_ctrl_pipe. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decode_ctrl_pipe_if #(.XLEN(32), .ALUOP_W(5)) bus ();

  decode_ctrl_pipe #(.XLEN(32), .ALUOP_W(5), .MDIV_LATENCY(4)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] I_DIV  = 32'h0220C3B3; // div  x7,x1,x2
  localparam logic [31:0] I_BEQ  = 32'h00208063; // beq  x1,x2,0

  // {alu[4:0], imm_type[2:0], WE, MR, MW, JAL, IS, OG, BR, J}
  function automatic logic [15:0] obs_bundle();
    return {bus.EX_ALU_OPCODE, bus.EX_IMMEDIATE_TYPE, bus.EX_WRITE_ENABLE,
            bus.EX_MEM_READ, bus.EX_MEM_WRITE, bus.EX_JUMP_AND_LINK,
            bus.EX_IMMEDIATE_SELECT, bus.EX_OFFSET_GENERATOR, bus.EX_BRANCH,
            bus.EX_JUMP};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.IF_VALID = 1'b0; bus.INSTRUCTION = 32'h0; bus.PC = 32'h0;
    bus.FLUSH = 1'b0; bus.EX_READY = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.EX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.EX_VALID); end
    checks++; if (bus.ID_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.ID_READY); end
    checks++; if (bus.MDIV_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.MDIV_BUSY); end
    checks++; if ({bus.EX_PC, obs_bundle()} !== 48'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", {bus.EX_PC, obs_bundle()}); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", bus.ID_READY); end
  endtask

  task automatic test_add();
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_ADD; bus.PC = 32'h100;
    @(negedge clk);
    bus.IF_VALID = 1'b0;
    checks++; if (bus.EX_VALID !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", bus.EX_VALID); end
    checks++; if (obs_bundle() !== 16'b00000_000_1000_0000) begin errors++; $display("FAIL add_bundle got %b want 0000000010000000", obs_bundle()); end
    checks++; if ({bus.EX_RD, bus.EX_RS1, bus.EX_RS2} !== {5'd3, 5'd1, 5'd2}) begin errors++; $display("FAIL add_regs got %0d/%0d/%0d want 3/1/2", bus.EX_RD, bus.EX_RS1, bus.EX_RS2); end
    checks++; if (bus.EX_PC !== 32'h100) begin errors++; $display("FAIL add_pc got %h want 100", bus.EX_PC); end
    @(negedge clk);
    checks++; if (bus.EX_VALID !== 1'b0) begin errors++; $display("FAIL add_drain_valid got %0b want 0", bus.EX_VALID); end
    checks++; if (bus.EX_RD !== 5'd3) begin errors++; $display("FAIL add_drain_hold got %0d want 3", bus.EX_RD); end
  endtask

  task automatic test_load_use();
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_LW; bus.PC = 32'h200;
    @(negedge clk);
    checks++; if (obs_bundle() !== 16'b00000_000_1100_1000 || bus.EX_RD !== 5'd5) begin errors++; $display("FAIL lw_bundle got %b rd %0d want 0000000011001000 rd 5", obs_bundle(), bus.EX_RD); end
    bus.INSTRUCTION = I_ADD6; bus.PC = 32'h204;
    #1;
    checks++; if (bus.ID_READY !== 1'b0) begin errors++; $display("FAIL hazard_ready got %0b want 0", bus.ID_READY); end
    @(negedge clk);
    checks++; if (bus.EX_VALID !== 1'b0) begin errors++; $display("FAIL hazard_bubble got %0b want 0", bus.EX_VALID); end
    checks++; if (bus.ID_READY !== 1'b1) begin errors++; $display("FAIL hazard_release got %0b want 1", bus.ID_READY); end
    @(negedge clk);
    bus.IF_VALID = 1'b0;
    checks++; if (bus.EX_VALID !== 1'b1 || bus.EX_RD !== 5'd6 || bus.EX_PC !== 32'h204) begin errors++; $display("FAIL hazard_issue got v%0b rd %0d pc %h want v1 rd 6 pc 204", bus.EX_VALID, bus.EX_RD, bus.EX_PC); end
  endtask

  task automatic test_div_block();
    int busy_cycles;
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_DIV; bus.PC = 32'h280;
    @(negedge clk);
    bus.IF_VALID = 1'b0;
    checks++; if (bus.EX_ALU_OPCODE !== 5'b01100 || bus.MDIV_BUSY !== 1'b0) begin errors++; $display("FAIL div_decode got alu %b busy %0b want 01100 busy 0", bus.EX_ALU_OPCODE, bus.MDIV_BUSY); end
    @(negedge clk);
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_ADD; bus.PC = 32'h284;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.MDIV_BUSY === 1'b1 && bus.ID_READY === 1'b0 && bus.EX_VALID === 1'b0) busy_cycles++;
      @(negedge clk);
    end
    checks++; if (busy_cycles !== 4) begin errors++; $display("FAIL div_busy_cycles got %0d want 4", busy_cycles); end
    #1;
    checks++; if (bus.MDIV_BUSY !== 1'b0 || bus.ID_READY !== 1'b1) begin errors++; $display("FAIL div_release got busy %0b ready %0b want 0 1", bus.MDIV_BUSY, bus.ID_READY); end
    @(negedge clk);
    bus.IF_VALID = 1'b0;
    checks++; if (bus.EX_VALID !== 1'b1 || bus.EX_PC !== 32'h284) begin errors++; $display("FAIL div_after_issue got v%0b pc %h want v1 pc 284", bus.EX_VALID, bus.EX_PC); end
  endtask

  task automatic test_branch_flush();
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_BEQ; bus.PC = 32'h300;
    @(negedge clk);
    checks++; if (obs_bundle() !== 16'b00000_100_0000_1110) begin errors++; $display("FAIL beq_bundle got %b want 0000010000001110", obs_bundle()); end
    bus.FLUSH = 1'b1; bus.INSTRUCTION = I_ADD6; bus.PC = 32'h304;
    #1;
    checks++; if (bus.ID_READY !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", bus.ID_READY); end
    @(negedge clk);
    bus.FLUSH = 1'b0; bus.IF_VALID = 1'b0;
    checks++; if (bus.EX_VALID !== 1'b0 || bus.EX_PC !== 32'h300) begin errors++; $display("FAIL flush_squash got v%0b pc %h want v0 pc 300", bus.EX_VALID, bus.EX_PC); end
    // flush also cancels a running divide block
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_DIV; bus.PC = 32'h308;
    @(negedge clk);
    bus.IF_VALID = 1'b0;
    @(negedge clk);
    checks++; if (bus.MDIV_BUSY !== 1'b1) begin errors++; $display("FAIL flush_div_armed got %0b want 1", bus.MDIV_BUSY); end
    bus.FLUSH = 1'b1;
    @(negedge clk);
    bus.FLUSH = 1'b0;
    checks++; if (bus.MDIV_BUSY !== 1'b0) begin errors++; $display("FAIL flush_div_clear got %0b want 0", bus.MDIV_BUSY); end
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    bus.IF_VALID = 1'b1; bus.INSTRUCTION = 32'hFFFFFFFF; bus.PC = 32'h400;
    @(negedge clk);
    bus.IF_VALID = 1'b0;
    checks++; if (bus.EX_VALID !== 1'b1 || bus.EX_ILLEGAL !== exp_ill) begin errors++; $display("FAIL illegal_flag got v%0b ill %0b want v1 ill %0b", bus.EX_VALID, bus.EX_ILLEGAL, exp_ill); end
    checks++; if (obs_bundle() !== 16'h0000) begin errors++; $display("FAIL illegal_bundle got %b want 0", obs_bundle()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr [9];
    logic [15:0] expv  [9];
    instr[0] = 32'h0020A023; expv[0] = 16'b00000_001_0010_1000; // sw
    instr[1] = 32'h000000EF; expv[1] = 16'b00000_010_1001_0101; // jal x1
    instr[2] = 32'h000012B7; expv[2] = 16'b10001_011_1000_1000; // lui x5
    instr[3] = 32'h00000297; expv[3] = 16'b00000_011_1000_1100; // auipc x5
    instr[4] = 32'h402081B3; expv[4] = 16'b00001_000_1000_0000; // sub
    instr[5] = 32'h0020B1B3; expv[5] = 16'b10010_000_1000_0000; // sltu
    instr[6] = 32'h4010D193; expv[6] = 16'b00111_000_1000_1000; // srai
    instr[7] = 32'h00208033; expv[7] = 16'b00000_000_0000_0000; // add x0
    instr[8] = 32'h000100E7; expv[8] = 16'b00000_000_1001_1001; // jalr x1
    bus.IF_VALID = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.INSTRUCTION = instr[i]; bus.PC = 32'h500 + 32'(4 * i);
      @(negedge clk);
      checks++; if (bus.EX_VALID !== 1'b1 || obs_bundle() !== expv[i] || bus.EX_PC !== 32'h500 + 32'(4 * i)) begin errors++; $display("FAIL b2b_%0d got v%0b %b pc %h want v1 %b", i, bus.EX_VALID, obs_bundle(), bus.EX_PC, expv[i]); end
    end
  endtask

  task automatic test_hold_reset();
    bus.EX_READY = 1'b0; bus.IF_VALID = 1'b1; bus.INSTRUCTION = I_ADD; bus.PC = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ID_READY !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d got %0b want 0", i, bus.ID_READY); end
      @(negedge clk);
      checks++; if (bus.EX_VALID !== 1'b1 || bus.EX_PC !== 32'h520 || obs_bundle() !== 16'b00000_000_1001_1001) begin errors++; $display("FAIL hold_stable_%0d got v%0b pc %h %b want v1 pc 520", i, bus.EX_VALID, bus.EX_PC, obs_bundle()); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.EX_VALID !== 1'b0 || bus.EX_PC !== 32'h0 || bus.EX_RD !== 5'd0 || obs_bundle() !== 16'h0 || bus.ID_READY !== 1'b0) begin errors++; $display("FAIL async_reset got v%0b pc %h rd %0d ready %0b want all 0", bus.EX_VALID, bus.EX_PC, bus.EX_RD, bus.ID_READY); end
    bus.IF_VALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_load_use();
    test_div_block();
    test_branch_flush();
    test_illegal();
    test_back_to_back();
    test_hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
